store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the core datapath's data-memory port and a slower,
//  handshaked data RAM. Stores are absorbed in one cycle and drained in FIFO order
//  over a req/ack bus. Loads check the buffer first; the youngest matching entry
//  forwards its data so read-after-write stays coherent. st_ready=0 stalls the core.
// PARAMETERS
//  DEPTH  4   entries; power of two, >=2
//  AW     32  address width (word address, same as the datapath mem_addr)
//  DW     32  data width
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low (0 = in reset)
//  st_valid   in   1   core store request (datapath memory write enable)
//  st_addr    in   AW  store address
//  st_data    in   DW  store data
//  st_ready   out  1   store accepted this cycle when st_valid&st_ready
//  ld_addr    in   AW  load address, combinational lookup
//  ld_hit     out  1   some valid entry matches ld_addr
//  ld_data    out  DW  data of the youngest matching entry; 0 when !ld_hit
//  mem_req    out  1   drain request for the head entry
//  mem_addr   out  AW  head address
//  mem_wdata  out  DW  head data
//  mem_ack    in   1   RAM accepted the head entry this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): count=0, wr_ptr=rd_ptr=0, all entries
//    invalid; st_ready=1, mem_req=0, ld_hit=0, ld_data=0, mem_addr=mem_wdata=0.
//  - Circular FIFO, pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0; count 0..DEPTH.
//  - st_ready = (count != DEPTH); purely from registered state, no push-through.
//  - Push on st_valid&st_ready: entry[wr_ptr] <= {addr,data}, wr_ptr++, count++.
//  - Drain: mem_req = (count != 0); mem_addr/mem_wdata = entry[rd_ptr], stable
//    until acked. mem_ack while mem_req: rd_ptr++, count--. mem_ack with mem_req=0
//    is ignored.
//  - Push and pop in the same cycle: both happen, count unchanged; legal when full
//    only if st_ready was 1 (it is not), so a full buffer accepts nothing that cycle.
//  - Empty buffer plus push: mem_req rises on the next cycle (1-cycle min latency).
//  - Forwarding: combinational search of valid entries, youngest to oldest. It sees
//    pre-edge state, so a store pushed in the same cycle is NOT visible to that load.
//    The head being drained still forwards until it is popped.
//  - Reset mid-drain: mem_req drops immediately. Unacked stores are discarded.
// CONFIGURATION
//  STORE_BUF_COALESCE_EN defined: a store whose address matches a valid non-head
//    entry overwrites the youngest such entry in place. No new entry is allocated
//    and count is unchanged. This is accepted even when full. The head entry is
//    never modified, because it is in flight. st_ready = !full | coalesce_match.
//  Not defined: every accepted store allocates a new entry; duplicate addresses
//    drain separately in program order.
// STRUCTURE
//  - store_buf_pkg: localparams SB_DEPTH_DEF, SB_PTR_W = $clog2(DEPTH), and the
//    entry field layout (ADDR_LSB/MSB, DATA_LSB/MSB) for a packed {addr,data} word.
//  - One sub-module sb_fwd_match: priority address compare over DEPTH entries,
//    given valid mask and rd_ptr. Returns hit, youngest index, and data. It is
//    instanced twice: once for the load forward, once for the coalesce lookup
//    (which masks out the head).
//  - Top level: pointers, count, entry regs, drain logic.
// TESTING
//  1 Reset: hold reset=0 with st_valid=1 -> st_ready=1, mem_req=0, count stays 0.
//    Release, push A=0x10 D=0xAA -> mem_req=1, mem_addr=0x10 on the next cycle.
//  2 Fill: push 0x1..0x4 with mem_ack=0 -> st_ready=0 after the 4th push. A 5th
//    st_valid is dropped. One mem_ack -> mem_addr=0x2, st_ready=1.
//  3 Forward: push (0x20,0x11), then (0x20,0x22), ld_addr=0x20 -> ld_hit=1,
//    ld_data=0x22. ld_addr=0x24 -> ld_hit=0, ld_data=0.
//  4 Push+pop same cycle at count=2 with mem_ack=1 -> count stays 2. Drain order is
//    preserved across pointer wrap (do 10 pushes/acks with DEPTH=4).
//  5 Reset mid-drain: 3 entries, mem_req=1, pulse reset=0 -> mem_req=0 in the same
//    cycle. After release, ld_hit=0 for all prior addresses.
//  6 COALESCE_EN: push 0x30,0x40,0x40(D=0x5) -> count=2, drained data for 0x40 is
//    0x5. Push 0x30 while 0x30 is head -> new entry allocated, count=3.

Source files
------------

// File: rtl/store_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : store_buf_pkg                                                   |
// | Brief    : Shared defaults and {addr,data} entry layout for store_buffer.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package store_buf_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_AW_DEF    = 32;
  localparam int SB_DW_DEF    = 32;
  localparam int SB_PTR_W     = $clog2(SB_DEPTH_DEF);

  // Packed entry word is {addr, data}, data in the low bits.
  localparam int SB_DATA_LSB  = 0;
  localparam int SB_DATA_MSB  = SB_DW_DEF - 1;
  localparam int SB_ADDR_LSB  = SB_DW_DEF;
  localparam int SB_ADDR_MSB  = SB_DW_DEF + SB_AW_DEF - 1;
  localparam int SB_ENTRY_W   = SB_AW_DEF + SB_DW_DEF;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sb_fwd_match                                                    |
// | Brief    : Priority address compare; returns youngest valid match.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sb_fwd_match
  import store_buf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = SB_AW_DEF,
  parameter int DW    = SB_DW_DEF
) (
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [$clog2(DEPTH)-1:0]         i_rd_ptr,
  input  logic [DEPTH-1:0][AW-1:0]         i_addr,
  input  logic [DEPTH-1:0][DW-1:0]         i_data,
  input  logic [AW-1:0]                    i_key,
  output logic                             o_hit,
  output logic [$clog2(DEPTH)-1:0]         o_idx,
  output logic [DW-1:0]                    o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_scan;

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_scan = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan = i_rd_ptr + PTR_W'(k);
      if (i_valid[w_scan] && (i_addr[w_scan] == i_key)) begin
        o_hit = 1'b1;
        o_idx = w_scan;
      end
    end
    o_data = o_hit ? i_data[o_idx] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : store_buffer                                                    |
// | Brief    : Posted-write FIFO with load forwarding, drained over req/ack.   |
// |            Define STORE_BUF_COALESCE_EN to merge stores into non-head      |
// |            entries with the same address.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = SB_AW_DEF,
  parameter int DW    = SB_DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int ENT_W    = AW + DW;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = DW - 1;
  localparam int ADDR_LSB = DW;
  localparam int ADDR_MSB = DW + AW - 1;
  localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);

  logic [ENT_W-1:0]          r_entry [DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W:0]            r_count;

  logic [DEPTH-1:0]          w_valid;
  logic [DEPTH-1:0][AW-1:0]  w_ent_addr;
  logic [DEPTH-1:0][DW-1:0]  w_ent_data;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_coal;
  logic [PTR_W-1:0]          w_coal_idx;

  // An entry is live when its distance from the head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [PTR_W-1:0] w_off;
    assign w_off         = PTR_W'(g) - r_rd_ptr;
    assign w_valid[g]    = {1'b0, w_off} < r_count;
    assign w_ent_addr[g] = r_entry[g][ADDR_MSB:ADDR_LSB];
    assign w_ent_data[g] = r_entry[g][DATA_MSB:DATA_LSB];
  end

  assign w_full    = (r_count == c_full);
  assign mem_req   = (r_count != '0);
  assign mem_addr  = w_ent_addr[r_rd_ptr];
  assign mem_wdata = w_ent_data[r_rd_ptr];
  assign w_pop     = mem_req & mem_ack;

  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ld_fwd (
    .i_valid  (w_valid),
    .i_rd_ptr (r_rd_ptr),
    .i_addr   (w_ent_addr),
    .i_data   (w_ent_data),
    .i_key    (ld_addr),
    .o_hit    (ld_hit),
    .o_idx    (),
    .o_data   (ld_data)
  );

`ifdef STORE_BUF_COALESCE_EN
  logic [DEPTH-1:0] w_head_mask;
  logic             w_coal_hit;

  // The head may already be on the bus, so it never takes a merge.
  assign w_head_mask = DEPTH'(1) << r_rd_ptr;

  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_coal_match (
    .i_valid  (w_valid & ~w_head_mask),
    .i_rd_ptr (r_rd_ptr),
    .i_addr   (w_ent_addr),
    .i_data   (w_ent_data),
    .i_key    (st_addr),
    .o_hit    (w_coal_hit),
    .o_idx    (w_coal_idx),
    .o_data   ()
  );

  assign st_ready = ~w_full | w_coal_hit;
  assign w_coal   = st_valid & w_coal_hit;
`else
  assign st_ready   = ~w_full;
  assign w_coal     = 1'b0;
  assign w_coal_idx = '0;
`endif

  assign w_push = st_valid & st_ready & ~w_coal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      if (w_coal) begin
        r_entry[w_coal_idx] <= {st_addr, st_data};
      end else if (w_push) begin
        r_entry[r_wr_ptr] <= {st_addr, st_data};
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_store_buffer                                                 |
// | Brief    : Scoreboard bench for store_buffer (STORE_BUF_COALESCE_EN aware).|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef STORE_BUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr  = '0;
  logic [DW-1:0] st_data  = '0;
  logic          st_ready;
  logic [AW-1:0] ld_addr  = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack  = 1'b0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sbq[$];
  ent_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Index of the youngest non-head expected entry with this address, or -1.
  function automatic int model_coal(input logic [AW-1:0] a);
    model_coal = -1;
    for (int i = 1; i < sbq.size(); i++) begin
      if (COAL && sbq[i].a == a) model_coal = i;
    end
  endfunction

  // Called at posedge+1 with inputs set; books the store before the edge.
  task automatic tick();
    int   ci;
    logic exp_rdy;
    #2;
    if (reset && st_valid) begin
      ci      = model_coal(st_addr);
      exp_rdy = (sbq.size() != DEPTH) || (ci >= 0);
      chk("st_ready", 64'(st_ready), 64'(exp_rdy));
      if (exp_rdy) begin
        if (ci >= 0) sbq[ci].d = st_data;
        else         sbq.push_back({st_addr, st_data});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    while (sbq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    mem_ack = 1'b0;
    chk("drain_left", 64'(sbq.size()), 64'd0);
    chk("mem_req_idle", 64'(mem_req), 64'd0);
  endtask

  // Drain monitor: every accepted head must be the oldest expected store.
  always @(negedge clk) begin
    if (reset && mem_req && mem_ack) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL drain_extra: got addr 0x%0h, required no drain", mem_addr);
      end else begin
        mon_e = sbq.pop_front();
        chk("drain_addr", 64'(mem_addr), 64'(mon_e.a));
        chk("drain_data", 64'(mem_wdata), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a store request pending.
    reset    = 1'b0;
    st_valid = 1'b1;
    st_addr  = 32'h77;
    st_data  = 32'h1;
    ld_addr  = 32'h77;
    #1;
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_ld_hit", 64'(ld_hit), 64'd0);
    chk("rst_ld_data", 64'(ld_data), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      @(posedge clk);
      #1;
    end
    reset    = 1'b1;
    st_valid = 1'b0;
    tick();
    chk("post_rst_mem_req", 64'(mem_req), 64'd0);
    chk("post_rst_ld_hit", 64'(ld_hit), 64'd0);

    // First store: request appears one cycle later.
    st_valid = 1'b1;
    st_addr  = 32'h10;
    st_data  = 32'hAA;
    chk("lat_before", 64'(mem_req), 64'd0);
    tick();
    st_valid = 1'b0;
    chk("lat_mem_req", 64'(mem_req), 64'd1);
    chk("lat_mem_addr", 64'(mem_addr), 64'h10);
    chk("lat_mem_wdata", 64'(mem_wdata), 64'hAA);
    drain();

    // Fill to full, drop a fifth store, then pop one.
    for (int i = 1; i <= 4; i++) put(AW'(i), DW'(32'h100 + i));
    st_addr = 32'h99;
    #1;
    chk("full_st_ready", 64'(st_ready), 64'd0);
    @(posedge clk);
    #1;
    put(32'h5, 32'h105);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("pop1_mem_addr", 64'(mem_addr), 64'h2);
    chk("pop1_st_ready", 64'(st_ready), 64'd1);
    drain();

    // Forwarding: youngest match wins; same-cycle store is invisible.
    put(32'h20, 32'h11);
    put(32'h20, 32'h22);
    ld_addr = 32'h20;
    #1;
    chk("fwd_hit", 64'(ld_hit), 64'd1);
    chk("fwd_data", 64'(ld_data), 64'h22);
    ld_addr = 32'h24;
    #1;
    chk("fwd_miss_hit", 64'(ld_hit), 64'd0);
    chk("fwd_miss_data", 64'(ld_data), 64'd0);
    st_valid = 1'b1;
    st_addr  = 32'h28;
    st_data  = 32'h33;
    ld_addr  = 32'h28;
    #1;
    chk("fwd_same_cycle", 64'(ld_hit), 64'd0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("fwd_next_hit", 64'(ld_hit), 64'd1);
    chk("fwd_next_data", 64'(ld_data), 64'h33);
    @(posedge clk);
    #1;
    drain();

    // Push and pop together at count 2 leaves count at 2.
    put(32'h31, 32'hA1);
    put(32'h32, 32'hA2);
    st_valid = 1'b1;
    st_addr  = 32'h33;
    st_data  = 32'hA3;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
    st_valid = 1'b0;
    put(32'h34, 32'hA4);
    put(32'h35, 32'hA5);
    st_addr = 32'h99;
    #1;
    chk("pushpop_full", 64'(st_ready), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Streaming across pointer wrap.
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1;
      st_addr  = AW'(32'h50 + i);
      st_data  = DW'(32'hC00 + i);
      tick();
    end
    st_valid = 1'b0;
    drain();

    // Asynchronous reset while draining.
    put(32'h61, 32'hB1);
    put(32'h62, 32'hB2);
    put(32'h63, 32'hB3);
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_st_ready", 64'(st_ready), 64'd1);
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_addr = AW'(32'h61 + i);
      #1;
      chk("midrst_ld_hit", 64'(ld_hit), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("midrst_after_req", 64'(mem_req), 64'd0);

`ifdef STORE_BUF_COALESCE_EN
    // Merge into a non-head entry; count stays at 2.
    put(32'h30, 32'h1);
    put(32'h40, 32'h2);
    put(32'h40, 32'h5);
    ld_addr = 32'h40;
    #1;
    chk("coal_fwd", 64'(ld_data), 64'h5);
    @(posedge clk);
    #1;
    put(32'h50, 32'h6);
    put(32'h60, 32'h7);
    st_addr = 32'h99;
    #1;
    chk("coal_count2", 64'(st_ready), 64'd0);
    @(posedge clk);
    #1;
    drain();
    // Head address never merges; full buffer still merges elsewhere.
    put(32'h30, 32'h8);
    put(32'h40, 32'h9);
    put(32'h30, 32'hA);
    put(32'h70, 32'hB);
    st_addr = 32'h99;
    #1;
    chk("coal_head_alloc", 64'(st_ready), 64'd0);
    st_addr = 32'h40;
    #1;
    chk("coal_full_ready", 64'(st_ready), 64'd1);
    @(posedge clk);
    #1;
    put(32'h40, 32'hC);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
